// File: rtl/svm_pkg.sv
// Shared types and width helpers for the SVM classifier datapath.
package svm_pkg;

  // Sequencer phases.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StCompute,
    StFlush,
    StDone
  } state_e;

  // Width of an index port (SV select, class select); one spare bit so a
  // count of exactly n is representable.
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/svm_idx_counter.sv
// Nested 3-level counter: level 0 innermost, level 2 outermost.
// Each level wraps at its own parameterised terminal value, not a power of two.
module svm_idx_counter #(
  parameter int unsigned N0 = 4,
  parameter int unsigned N1 = 2,
  parameter int unsigned N2 = 2,
  parameter int unsigned W0 = 2,
  parameter int unsigned W1 = 2,
  parameter int unsigned W2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [W0-1:0] cnt0_o,
  output logic [W1-1:0] cnt1_o,
  output logic [W2-1:0] cnt2_o,
  output logic          last0_o,
  output logic          last_all_o
);

  logic [W0-1:0] cnt0_q;
  logic [W1-1:0] cnt1_q;
  logic [W2-1:0] cnt2_q;
  logic          last0, last1, last2;

  // Terminal flags per level.
  always_comb begin
    last0 = (cnt0_q == W0'(N0 - 1));
    last1 = (cnt1_q == W1'(N1 - 1));
    last2 = (cnt2_q == W2'(N2 - 1));
  end

  // Advance innermost level; carry outward on each terminal.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else if (en_i) begin
      cnt0_q <= last0 ? '0 : cnt0_q + W0'(1);
      if (last0) begin
        cnt1_q <= last1 ? '0 : cnt1_q + W1'(1);
        if (last1) begin
          cnt2_q <= last2 ? '0 : cnt2_q + W2'(1);
        end
      end
    end
  end

  assign cnt0_o     = cnt0_q;
  assign cnt1_o     = cnt1_q;
  assign cnt2_o     = cnt2_q;
  assign last0_o    = last0;
  assign last_all_o = last0 && last1 && last2;

endmodule

// File: rtl/svm_mem_sequencer.sv
// Load / drain / compute sequencer for the cascaded SVM decision function.
module svm_mem_sequencer
  import svm_pkg::*;
#(
  parameter int unsigned XLEN_PIXEL    = 8,
  parameter int unsigned NUM_OF_PIXELS = 784,
  parameter int unsigned NUM_OF_SV     = 10,
  parameter int unsigned NUM_CLASSES   = 2,
  parameter int unsigned DRAIN_CYCLES  = 10,
  parameter int unsigned AW            = $clog2(NUM_OF_PIXELS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [XLEN_PIXEL-1:0]               in_pixel,
  output logic                                in_ready,
  input  logic                                df_stall,
  output logic                                mem_we,
  output logic                                mem_re,
  output logic [AW-1:0]                       mem_addr,
  output logic [XLEN_PIXEL-1:0]               mem_wdata,
  output logic [$clog2(NUM_OF_SV):0]          sv_idx,
  output logic [$clog2(NUM_CLASSES):0]        class_idx,
  output logic                                stall_mem,
  output logic                                df_en,
  output logic                                df_first,
  output logic                                df_last,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned SW = idx_width(NUM_OF_SV);
  localparam int unsigned CW = idx_width(NUM_CLASSES);
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            df_en_q, df_first_q, df_last_q;

  logic [AW-1:0]   pix_cnt;
  logic [SW-1:0]   sv_cnt;
  logic [CW-1:0]   cls_cnt;
  logic            pix_last, sweep_last;
  logic            hs, rd;

  assign hs = (state_q == StLoad) && in_valid;
  assign rd = (state_q == StCompute) && !df_stall;

  // Read sweep counters; held at zero outside COMPUTE so each run starts clean.
  svm_idx_counter #(
    .N0 (NUM_OF_PIXELS),
    .N1 (NUM_OF_SV),
    .N2 (NUM_CLASSES),
    .W0 (AW),
    .W1 (SW),
    .W2 (CW)
  ) u_idx_counter (
    .clk        (clk),
    .rst        (rst),
    .en_i       (rd),
    .clr_i      (state_q != StCompute),
    .cnt0_o     (pix_cnt),
    .cnt1_o     (sv_cnt),
    .cnt2_o     (cls_cnt),
    .last0_o    (pix_last),
    .last_all_o (sweep_last)
  );

  // State and phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state and phase counter update.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (hs) begin
          if (wr_cnt_q == AW'(NUM_OF_PIXELS - 1)) begin
            wr_cnt_d = '0;
            state_d  = StDrain;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          drain_cnt_d = '0;
          state_d     = StCompute;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      StCompute: begin
        if (rd && sweep_last) state_d = StFlush;
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory port drive; write and read phases are mutually exclusive by state.
  always_comb begin
    in_ready  = (state_q == StLoad);
    mem_we    = hs;
    mem_re    = rd;
    mem_wdata = hs ? in_pixel : '0;
    mem_addr  = '0;
    sv_idx    = '0;
    class_idx = '0;
    if (hs) begin
      mem_addr = wr_cnt_q;
    end else if (rd) begin
      mem_addr  = pix_cnt;
      sv_idx    = sv_cnt;
      class_idx = cls_cnt;
    end
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // One-cycle read pipeline matching the x-buffer/ROM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      df_en_q    <= 1'b0;
      df_first_q <= 1'b0;
      df_last_q  <= 1'b0;
    end else begin
      df_en_q    <= rd;
      df_first_q <= rd && (pix_cnt == '0);
      df_last_q  <= rd && pix_last;
    end
  end

  assign df_en     = df_en_q;
  assign df_first  = df_first_q;
  assign df_last   = df_last_q;
  assign stall_mem = !df_en_q;

endmodule

// File: tb/tb_svm_mem_sequencer.sv
// Directed bench for svm_mem_sequencer with a 4-pixel, 2-SV, 2-class setup.
module tb_svm_mem_sequencer;

  localparam int NPIX = 4;
  localparam int NSV  = 2;
  localparam int NCLS = 2;
  localparam int NRD  = NPIX * NSV * NCLS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       df_stall = 1'b0;
  logic       in_ready, mem_we, mem_re;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [1:0] sv_idx, class_idx;
  logic       stall_mem, df_en, df_first, df_last, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int done_cnt = 0;
  bit mon_on  = 1'b0;
  bit exp_en = 1'b0, exp_first = 1'b0, exp_last = 1'b0;

  svm_mem_sequencer #(
    .XLEN_PIXEL    (8),
    .NUM_OF_PIXELS (NPIX),
    .NUM_OF_SV     (NSV),
    .NUM_CLASSES   (NCLS),
    .DRAIN_CYCLES  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .df_stall  (df_stall),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .sv_idx    (sv_idx),
    .class_idx (class_idx),
    .stall_mem (stall_mem),
    .df_en     (df_en),
    .df_first  (df_first),
    .df_last   (df_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pipeline model: df_* are last cycle's read qualifiers unless reset hit.
  always @(negedge clk) begin
    if (mon_on) begin
      check_eq("df_en", df_en, exp_en);
      check_eq("df_first", df_first, exp_first);
      check_eq("df_last", df_last, exp_last);
      check_eq("stall_mem", stall_mem, !exp_en);
      check_eq("we_re_excl", mem_we && mem_re, 0);
      if (mem_re) rd_cnt++;
      if (done) done_cnt++;
    end
    exp_en    = mem_re && !rst;
    exp_first = exp_en && (mem_addr == 2'd0);
    exp_last  = exp_en && (mem_addr == 2'd3);
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_stall_mem"}, stall_mem, 1);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_mem_we"}, mem_we, 0);
    check_eq({tag, "_mem_re"}, mem_re, 0);
    check_eq({tag, "_df_en"}, df_en, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check_eq("load_in_ready", in_ready, 1);
    check_eq("load_busy", busy, 1);
  endtask

  // Stream one image, optionally with an idle cycle between handshakes, then drain.
  task automatic load_image(input int base, input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      in_valid = 1'b1;
      in_pixel = 8'(base + i);
      #1;
      check_eq("wr_we", mem_we, 1);
      check_eq("wr_addr", mem_addr, i);
      check_eq("wr_data", mem_wdata, base + i);
      tick();
      if (gaps && i < NPIX - 1) begin
        in_valid = 1'b0;
        #1;
        check_eq("gap_we", mem_we, 0);
        check_eq("gap_in_ready", in_ready, 1);
        tick();
      end
    end
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      #1;
      check_eq("drain_stall_mem", stall_mem, 1);
      check_eq("drain_mem_re", mem_re, 0);
      check_eq("drain_in_ready", in_ready, 0);
      check_eq("drain_busy", busy, 1);
      tick();
    end
  endtask

  // Sweep reads, checking class-major order; optional stall, start pulse, abort.
  task automatic run_compute(input int stall_at, input int start_at, input int abort_at,
                             output bit aborted);
    int k = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    aborted = 1'b0;
    while (k < NRD && cyc < 200 && !aborted) begin
      df_stall = 1'b0;
      start = 1'b0;
      if (k == stall_at && !stalled) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        df_stall = 1'b1;
        stall_left--;
      end
      if (k == start_at) start = 1'b1;
      if (k == abort_at && !df_stall) rst = 1'b1;
      #1;
      if (df_stall) begin
        check_eq("stall_mem_re", mem_re, 0);
      end else begin
        check_eq("rd_re", mem_re, 1);
        check_eq("rd_pix", mem_addr, k % NPIX);
        check_eq("rd_sv", sv_idx, (k / NPIX) % NSV);
        check_eq("rd_cls", class_idx, k / (NPIX * NSV));
        k++;
      end
      if (rst) aborted = 1'b1;
      tick();
      cyc++;
    end
    df_stall = 1'b0;
    start = 1'b0;
    if (!aborted) check_eq("compute_reads", k, NRD);
  endtask

  task automatic finish_run(input int rd0, input int done0);
    #1;
    check_eq("flush_mem_re", mem_re, 0);
    check_eq("flush_done", done, 0);
    check_eq("flush_df_en", df_en, 1);
    tick();
    #1;
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 1);
    tick();
    #1;
    check_eq("post_done", done, 0);
    check_eq("post_busy", busy, 0);
    tick();
    check_eq("run_reads", rd_cnt - rd0, NRD);
    check_eq("run_dones", done_cnt - done0, 1);
  endtask

  initial begin
    bit ab;
    int rd0, done0;
    // 1: reset and idle
    tick();
    tick();
    rst = 1'b0;
    mon_on = 1'b1;
    tick();
    tick();
    check_idle("reset");

    // 2+3: contiguous load then full sweep
    rd0 = rd_cnt; done0 = done_cnt;
    do_start();
    load_image(200, 1'b0);
    run_compute(-1, -1, -1, ab);
    finish_run(rd0, done0);

    // 4: in_valid toggling during load
    rd0 = rd_cnt; done0 = done_cnt;
    do_start();
    load_image(10, 1'b1);
    run_compute(-1, -1, -1, ab);
    finish_run(rd0, done0);

    // 5: back-pressure at c0s1p2
    rd0 = rd_cnt; done0 = done_cnt;
    do_start();
    load_image(50, 1'b0);
    run_compute(6, -1, -1, ab);
    finish_run(rd0, done0);

    // 7: start pulsed mid-compute is ignored
    rd0 = rd_cnt; done0 = done_cnt;
    do_start();
    load_image(70, 1'b0);
    run_compute(-1, 5, -1, ab);
    finish_run(rd0, done0);

    // 6: reset at c1s0p1, then immediate restart
    done0 = done_cnt;
    do_start();
    load_image(90, 1'b0);
    run_compute(-1, -1, 9, ab);
    check_eq("abort_taken", ab, 1);
    check_idle("abort");
    rst = 1'b0;
    rd0 = rd_cnt;
    do_start();
    check_eq("abort_no_done", done_cnt - done0, 0);
    load_image(120, 1'b0);
    run_compute(-1, -1, -1, ab);
    finish_run(rd0, done0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_mem_sequencer.md
Name: svm_mem_sequencer

Overview:
Parametrised successor to the single-shot memory controller. It runs load, drain and compute phases under a start/done handshake. Test pixels stream into the x-buffer through a valid/ready port; reads are then sequenced over every (class, support vector, pixel) triple, with aligned first/last markers driving the cascaded decision-function datapath. Supports multiple cascade classes, back-pressure and repeated classifications without a reset.

Parameters:
XLEN_PIXEL, 8, pixel width in bits
NUM_OF_PIXELS, 784, pixels per test image (>=2)
NUM_OF_SV, 10, support vectors per class (>=1)
NUM_CLASSES, 2, cascade stages / binary classifiers (>=1)
DRAIN_CYCLES, 10, stall cycles between last write and first read (>=1)
AW, $clog2(NUM_OF_PIXELS), x-buffer address width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin one classification; sampled in IDLE only
in_valid  in  1  test pixel valid
in_pixel  in  XLEN_PIXEL  test pixel data
in_ready  out  1  pixel accepted when in_valid & in_ready
df_stall  in  1  decision-function back-pressure
mem_we  out  1  x-buffer write enable
mem_re  out  1  x-buffer and SV-ROM read enable
mem_addr  out  AW  pixel address (write or read)
mem_wdata  out  XLEN_PIXEL  write data
sv_idx  out  $clog2(NUM_OF_SV)+1  SV-ROM select
class_idx  out  $clog2(NUM_CLASSES)+1  class / cascade-stage select
stall_mem  out  1  high whenever read data is not being produced
df_en  out  1  read data valid to decision function (1 cycle after mem_re)
df_first  out  1  with df_en: pixel 0 of the current SV
df_last  out  1  with df_en: last pixel of the current SV
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of classification

Behaviour:
- Reset state: IDLE. All outputs 0 except stall_mem=1. All counters cleared. Reset mid-operation aborts immediately, with no done pulse.
- IDLE: stall_mem=1. On start go to LOAD. A start asserted in any other state is ignored.
- LOAD: in_ready=1. On each handshake: mem_we=1, mem_wdata=in_pixel, mem_addr=pix_cnt, all combinational with the handshake; pix_cnt increments. After handshake number NUM_OF_PIXELS, pix_cnt clears and the FSM goes to DRAIN. in_valid=0 simply waits, with no timeout.
- DRAIN: counts DRAIN_CYCLES cycles with stall_mem=1, then goes to COMPUTE.
- COMPUTE: each cycle with df_stall=0, assert mem_re=1 with mem_addr=pix_cnt, sv_idx=sv_cnt, class_idx=cls_cnt. Then advance the nested counters: pixel innermost, SV middle, class outermost.
- COMPUTE with df_stall=1: mem_re=0 and all counters hold.
- After the read of (last class, last SV, last pixel), go to FLUSH.
- FLUSH: one cycle, so the final df_en is emitted. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Read pipeline: df_en, df_first and df_last are registered copies of mem_re, (pix_cnt==0) and (pix_cnt==NUM_OF_PIXELS-1), so latency is 1 cycle. df_first and df_last are 0 whenever df_en=0.
- stall_mem = ~df_en registered-consistent: 0 only in cycles where df_en=1.
- Total reads per classification: NUM_CLASSES*NUM_OF_SV*NUM_OF_PIXELS. Each triple is read exactly once, in order, with no duplicates under stall.
- Counters have no wrap beyond their terminal values. Terminal compares use the parameters, not power-of-two widths.
- mem_we and mem_re are never high in the same cycle.

Decomposition:
- Package svm_pkg: state enum (IDLE, LOAD, DRAIN, COMPUTE, FLUSH, DONE) and the clog2-derived width constants shared with the decision-function and SV-ROM blocks.
- One natural sub-module: svm_idx_counter. It is a parametrised nested 3-level counter with enable, clear and terminal flags, instantiated for the COMPUTE sweep.

Test Plan:
All scenarios use params NUM_OF_PIXELS=4, NUM_OF_SV=2, NUM_CLASSES=2, DRAIN_CYCLES=3.
1. Reset, then idle with start=0 -> stall_mem=1, busy=0; in_ready, mem_we, mem_re, df_en and done all 0.
2. Start, then in_valid held high with pixels 200..203 -> 4 writes at addr 0..3 with wdata 200..203. Then 3 drain cycles with stall_mem=1. First mem_re occurs in the next cycle at addr0, sv0, class0.
3. Continuation of scenario 2 with df_stall=0 -> 16 consecutive reads ordered class-major (c0s0p0..p3, c0s1.., c1s0.., c1s1..). df_en follows each read by 1 cycle; df_first/df_last fall on p0/p3. done pulses once, 2 cycles after the last read.
4. In_valid toggled 1,0,1,0 during LOAD -> writes occur only on handshake cycles, addresses remain contiguous 0..3, and DRAIN starts after the 4th write.
5. df_stall=1 for 3 cycles at c0s1p2 -> mem_re=0 for 3 cycles and counters hold. The resumed read is c0s1p2; total reads stay 16 with no duplicates.
6. rst at read c1s0p1, then immediate start -> no done pulse, outputs return to reset values, and a fresh LOAD begins at addr 0.
7. Start pulsed during COMPUTE -> ignored: exactly one done pulse, read count unchanged.
